// File: rtl/control_alu_32_pkg.sv
// Shared decode constants for the single-cycle MIPS-subset control/ALU slice.
// Opcodes, ALUOp classes, ALU-control function codes and ALU operation selects.
package control_alu_32_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // ALUOp 2'b11 is never produced by the main decoder but decodes like 2'b10.
    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_CTL_AND = 4'b0000,
        ALU_CTL_OR  = 4'b0001,
        ALU_CTL_ADD = 4'b0010,
        ALU_CTL_SUB = 4'b0110,
        ALU_CTL_SLT = 4'b0111,
        ALU_CTL_NOR = 4'b1100
    } alu_ctl_e;

    localparam logic [3:0] FC_ADD = 4'b0000;
    localparam logic [3:0] FC_SUB = 4'b0010;
    localparam logic [3:0] FC_AND = 4'b0100;
    localparam logic [3:0] FC_OR  = 4'b0101;
    localparam logic [3:0] FC_NOR = 4'b0111;
    localparam logic [3:0] FC_SLT = 4'b1010;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_alu_32_alu.sv
// Combinational 32-bit ALU: and/or/add/sub/slt/nor with carry, overflow, slt and zero flags.
// slt always comes from the internal subtraction, independent of the selected op.
module alu_32
    import control_alu_32_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_ctl,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero
);

    logic [N:0] add_sum;
    logic [N:0] sub_sum;
    logic       add_ovf;
    logic       sub_ovf;

    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        // carry into the MSB is recovered as a ^ b ^ sum at that bit
        add_ovf = (a[N-1] ^ b[N-1] ^ add_sum[N-1]) ^ add_sum[N];
        sub_ovf = (a[N-1] ^ ~b[N-1] ^ sub_sum[N-1]) ^ sub_sum[N];
        slt     = sub_sum[N-1] ^ sub_ovf;
    end

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (alu_ctl)
            ALU_CTL_AND: result = a & b;
            ALU_CTL_OR:  result = a | b;
            ALU_CTL_ADD: begin
                result   = add_sum[N-1:0];
                cout     = add_sum[N];
                overflow = add_ovf;
            end
            ALU_CTL_SUB: begin
                result   = sub_sum[N-1:0];
                cout     = sub_sum[N];
                overflow = sub_ovf;
            end
            ALU_CTL_SLT: result = {{(N-1){1'b0}}, slt};
            ALU_CTL_NOR: result = ~(a | b);
            default:     result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/control_alu_32.sv
// Single-cycle execute/control block: main decoder, ALU-control decoder and ALU.
// All outputs are combinational except flags_q, a registered debug copy of the flags.
module control_alu_32
    import control_alu_32_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         reg_dst,
    output logic         alu_src,
    output logic         mem_to_reg,
    output logic         reg_write,
    output logic         mem_read,
    output logic         mem_write,
    output logic         branch,
    output logic [1:0]   alu_op,
    output logic [3:0]   alu_ctl,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic         slt,
    output logic         zero,
    output logic [3:0]   flags_q
);

    ctrl_t    ctrl;
    logic [3:0] fc;
    alu_ctl_e alu_ctl_c;
    logic     funct_hi_unused;

    assign funct_hi_unused = ^funct[5:4];

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            default: ctrl.alu_op = ALUOP_ADD;
        endcase
    end

    assign reg_dst    = ctrl.reg_dst;
    assign alu_src    = ctrl.alu_src;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign branch     = ctrl.branch;
    assign alu_op     = ctrl.alu_op;

    // Immediate ops have no funct field, so they borrow the matching R-type code.
    always_comb begin
        fc = funct[3:0];
        case (opcode)
            OP_ADDI: fc = FC_ADD;
            OP_ANDI: fc = FC_AND;
            OP_ORI:  fc = FC_OR;
            default: fc = funct[3:0];
        endcase
    end

    always_comb begin
        alu_ctl_c = ALU_CTL_ADD;
        case (ctrl.alu_op)
            ALUOP_ADD: alu_ctl_c = ALU_CTL_ADD;
            ALUOP_SUB: alu_ctl_c = ALU_CTL_SUB;
            default: begin
                case (fc)
                    FC_ADD:  alu_ctl_c = ALU_CTL_ADD;
                    FC_SUB:  alu_ctl_c = ALU_CTL_SUB;
                    FC_AND:  alu_ctl_c = ALU_CTL_AND;
                    FC_OR:   alu_ctl_c = ALU_CTL_OR;
                    FC_NOR:  alu_ctl_c = ALU_CTL_NOR;
                    FC_SLT:  alu_ctl_c = ALU_CTL_SLT;
                    default: alu_ctl_c = ALU_CTL_ADD;
                endcase
            end
        endcase
    end

    assign alu_ctl = alu_ctl_c;

    alu_32 #(
        .N (N)
    ) u_alu (
        .a        (a),
        .b        (b),
        .alu_ctl  (alu_ctl),
        .result   (result),
        .cout     (cout),
        .slt      (slt),
        .overflow (overflow),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= {cout, overflow, slt, zero};
        end
    end

endmodule

// File: tb/tb_control_alu_32.sv
// Directed scoreboard bench for control_alu_32: decode strobes, ALU results, flags and flags_q.
module tb_control_alu_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        cout, overflow, slt, zero;
    logic [3:0]  flags_q;

    typedef struct {
        string       tag;
        logic [8:0]  ctrl;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] C_IMM  = 9'b0_1_0_1_0_0_0_10;
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_00;

    control_alu_32 #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_op     (alu_op),
        .alu_ctl    (alu_ctl),
        .result     (result),
        .cout       (cout),
        .overflow   (overflow),
        .slt        (slt),
        .zero       (zero),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [8:0] ectrl, input logic [3:0] ectl,
                         input logic [31:0] eres, input logic [3:0] eflags);
        exp_t e;
        @(negedge clk);
        opcode = op;
        funct  = fn;
        a      = aa;
        b      = bb;
        e.tag = tag; e.ctrl = ectrl; e.ctl = ectl; e.res = eres; e.flags = eflags;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, ".ctrl"}, 32'({reg_dst, alu_src, mem_to_reg, reg_write,
                                    mem_read, mem_write, branch, alu_op}), 32'(e.ctrl));
        chk({e.tag, ".alu_ctl"}, 32'(alu_ctl), 32'(e.ctl));
        chk({e.tag, ".result"}, result, e.res);
        chk({e.tag, ".flags"}, 32'({cout, overflow, slt, zero}), 32'(e.flags));
        @(posedge clk);
        #1;
        chk({e.tag, ".flags_q"}, 32'(flags_q), 32'(e.flags));
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; a = '0; b = '0;
        #2;
        chk("reset.flags_q", 32'(flags_q), 32'd0);
        @(posedge clk); #1;
        chk("reset_hold.flags_q", 32'(flags_q), 32'd0);
        @(negedge clk); rst = 1'b0;

        drive("r_add", 6'b000000, 6'b100000, 32'd7, 32'd5, C_R, 4'b0010, 32'd12, 4'b0000);
        check_out();
        drive("add_ovf", 6'b000000, 6'b100000, 32'h7FFFFFFF, 32'h1, C_R, 4'b0010, 32'h80000000, 4'b0100);
        check_out();
        drive("add_carry", 6'b000000, 6'b100000, 32'hFFFFFFFF, 32'h1, C_R, 4'b0010, 32'h0, 4'b1011);
        check_out();
        drive("beq", 6'b000100, 6'b000000, 32'h1234, 32'h1234, C_BEQ, 4'b0110, 32'h0, 4'b1001);
        check_out();
        drive("slt_wrap", 6'b000000, 6'b101010, 32'h80000000, 32'h1, C_R, 4'b0111, 32'h1, 4'b0010);
        check_out();
        drive("ori", 6'b001101, 6'b000000, 32'hF0, 32'h0F, C_IMM, 4'b0001, 32'hFF, 4'b0000);
        check_out();
        drive("lw", 6'b100011, 6'b000000, 32'h100, 32'h8, C_LW, 4'b0010, 32'h108, 4'b0000);
        check_out();
        drive("r_sub", 6'b000000, 6'b100010, 32'd5, 32'd7, C_R, 4'b0110, 32'hFFFFFFFE, 4'b0010);
        check_out();
        drive("r_and", 6'b000000, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, C_R, 4'b0000, 32'h0F000F00, 4'b0010);
        check_out();
        drive("r_nor", 6'b000000, 6'b100111, 32'h0, 32'h0, C_R, 4'b1100, 32'hFFFFFFFF, 4'b0000);
        check_out();
        drive("andi", 6'b001100, 6'b111111, 32'hFFFFFFFF, 32'h0000FFFF, C_IMM, 4'b0000, 32'h0000FFFF, 4'b0010);
        check_out();
        drive("addi", 6'b001000, 6'b100010, 32'h10, 32'hFFFFFFFF, C_IMM, 4'b0010, 32'hF, 4'b1000);
        check_out();
        drive("sw", 6'b101011, 6'b000000, 32'h1000, 32'hFFFFFFFC, C_SW, 4'b0010, 32'hFFC, 4'b1000);
        check_out();
        drive("bad_op", 6'b000010, 6'b100010, 32'd3, 32'd4, C_NONE, 4'b0010, 32'd7, 4'b0010);
        check_out();
        drive("bad_funct", 6'b000000, 6'b000110, 32'd1, 32'd2, C_R, 4'b0010, 32'd3, 4'b0010);
        check_out();
        drive("slt_ext", 6'b000000, 6'b101010, 32'h7FFFFFFF, 32'h80000000, C_R, 4'b0111, 32'h0, 4'b0001);
        check_out();
        drive("sub_ovf", 6'b000000, 6'b100010, 32'h80000000, 32'h1, C_R, 4'b0110, 32'h7FFFFFFF, 4'b1110);
        check_out();

        // inputs from sub_ovf stay applied; flags_q currently holds 4'b1110
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid.flags_q", 32'(flags_q), 32'd0);
        chk("rst_mid.result", result, 32'h7FFFFFFF);
        chk("rst_mid.flags", 32'({cout, overflow, slt, zero}), 32'(4'b1110));
        @(posedge clk); #1;
        chk("rst_held.flags_q", 32'(flags_q), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release.flags_q", 32'(flags_q), 32'(4'b1110));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
